// File: rtl/uart_boot_loader.sv
// UART boot loader: receives a length-prefixed little-endian image from a
// UART byte stream, writes it word by word into instruction memory and holds
// the CPU in reset until the image is complete. Any gap that is too long, or a
// word count larger than the memory, aborts the load until the next reset.
module uart_boot_loader #(
  parameter int ADDR_WIDTH     = 10,
  parameter int TIMEOUT_CYCLES = 400_000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [31:0]           imem_wdata,
  output logic                  cpu_hold,
  output logic                  load_done,
  output logic                  load_err
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);
  // Memory capacity in words; 17 bits so a full 16-bit count compares cleanly.
  localparam logic [16:0] CAPACITY = 17'(1 << ADDR_WIDTH);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_HDR  = 3'd1,
    ST_DATA = 3'd2,
    ST_DONE = 3'd3,
    ST_ERR  = 3'd4
  } state_t;

  state_t                state_r, state_s;
  logic [7:0]            n_lo_r, n_lo_s;
  logic [15:0]           n_s;
  logic [31:0]           asm_r, asm_s;
  logic [1:0]            idx_r, idx_s;
  logic [ADDR_WIDTH-1:0] waddr_r, waddr_s;
  logic [16:0]           rem_r, rem_s;
  logic [TW-1:0]         timer_r, timer_s;
  logic                  we_s;
  logic [ADDR_WIDTH-1:0] addr_s;
  logic [31:0]           wdata_s;

  // Next-state, datapath and write-strobe decode for the load sequence.
  always_comb begin
    state_s = state_r;
    n_lo_s  = n_lo_r;
    n_s     = {rx_data, n_lo_r};
    asm_s   = asm_r;
    idx_s   = idx_r;
    waddr_s = waddr_r;
    rem_s   = rem_r;
    timer_s = timer_r;
    we_s    = 1'b0;
    addr_s  = imem_addr;
    wdata_s = imem_wdata;
    case (state_r)
      ST_IDLE: begin
        timer_s = {TW{1'b0}};
        if (rx_valid) begin
          n_lo_s  = rx_data;
          state_s = ST_HDR;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_HDR: begin
        if (rx_valid) begin
          timer_s = {TW{1'b0}};
          if (n_s == 16'd0) begin
            state_s = ST_DONE;
          end else if ({1'b0, n_s} > CAPACITY) begin
            state_s = ST_ERR;
          end else begin
            state_s = ST_DATA;
            idx_s   = 2'd0;
            waddr_s = {ADDR_WIDTH{1'b0}};
            rem_s   = {1'b0, n_s};
          end
        end else begin
          timer_s = timer_r + 1'b1;
          if (timer_r == TIMER_LAST) begin
            state_s = ST_ERR;
          end else begin
            state_s = ST_HDR;
          end
        end
      end
      ST_DATA: begin
        if (rem_r == 17'd0) begin
          // The final word was written last cycle; the image is complete.
          state_s = ST_DONE;
        end else if (rx_valid) begin
          timer_s = {TW{1'b0}};
          idx_s   = idx_r + 2'd1;
          case (idx_r)
            2'd0:    asm_s[7:0]   = rx_data;
            2'd1:    asm_s[15:8]  = rx_data;
            2'd2:    asm_s[23:16] = rx_data;
            2'd3:    asm_s[31:24] = rx_data;
            default: asm_s        = asm_r;
          endcase
          if (idx_r == 2'd3) begin
            // Only a fully assembled word ever reaches the memory.
            we_s    = 1'b1;
            addr_s  = waddr_r;
            wdata_s = {rx_data, asm_r[23:0]};
            waddr_s = waddr_r + 1'b1;
            rem_s   = rem_r - 17'd1;
          end else begin
            we_s = 1'b0;
          end
        end else begin
          timer_s = timer_r + 1'b1;
          if (timer_r == TIMER_LAST) begin
            state_s = ST_ERR;
          end else begin
            state_s = ST_DATA;
          end
        end
      end
      ST_DONE: state_s = ST_DONE;
      ST_ERR:  state_s = ST_ERR;
      default: state_s = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Header, assembly, addressing and timeout registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      n_lo_r  <= 8'd0;
      asm_r   <= 32'd0;
      idx_r   <= 2'd0;
      waddr_r <= {ADDR_WIDTH{1'b0}};
      rem_r   <= 17'd0;
      timer_r <= {TW{1'b0}};
    end else begin
      n_lo_r  <= n_lo_s;
      asm_r   <= asm_s;
      idx_r   <= idx_s;
      waddr_r <= waddr_s;
      rem_r   <= rem_s;
      timer_r <= timer_s;
    end
  end

  // Registered outputs; status flags follow the state being entered.
  always_ff @(posedge clk) begin
    if (reset) begin
      imem_we    <= 1'b0;
      imem_addr  <= {ADDR_WIDTH{1'b0}};
      imem_wdata <= 32'd0;
      cpu_hold   <= 1'b1;
      load_done  <= 1'b0;
      load_err   <= 1'b0;
    end else begin
      imem_we    <= we_s;
      imem_addr  <= addr_s;
      imem_wdata <= wdata_s;
      cpu_hold   <= (state_s != ST_DONE);
      load_done  <= (state_s == ST_DONE);
      load_err   <= (state_s == ST_ERR);
    end
  end

endmodule

// File: tb/tb_uart_boot_loader.sv
// Self-checking bench for uart_boot_loader: directed boot scenarios plus
// randomized images compared against a word-list reference model.
module tb_uart_boot_loader;

  localparam int AW = 4;
  localparam int TO = 100;
  localparam int CAP = 1 << AW;

  logic          clk = 1'b0;
  logic          reset;
  logic [7:0]    rx_data;
  logic          rx_valid;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic          cpu_hold;
  logic          load_done;
  logic          load_err;

  uart_boot_loader #(.ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)) dut (
    .clk       (clk),
    .reset     (reset),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .imem_we   (imem_we),
    .imem_addr (imem_addr),
    .imem_wdata(imem_wdata),
    .cpu_hold  (cpu_hold),
    .load_done (load_done),
    .load_err  (load_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int last_we_cyc = 0;
  int done_cyc    = 0;
  bit done_seen   = 1'b0;
  logic [AW-1:0] got_addr[$];
  logic [31:0]   got_data[$];
  logic [AW-1:0] exp_addr[$];
  logic [31:0]   exp_data[$];

  // Cycle counter used to time strobes against status flags.
  always @(posedge clk) cyc <= cyc + 1;

  // Write monitor: records every memory write and the first load_done cycle.
  always @(negedge clk) begin
    if (imem_we === 1'b1) begin
      got_addr.push_back(imem_addr);
      got_data.push_back(imem_wdata);
      last_we_cyc = cyc;
    end
    if (load_done === 1'b1 && !done_seen) begin
      done_seen = 1'b1;
      done_cyc  = cyc;
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic clear_mon();
    got_addr.delete();
    got_data.delete();
    exp_addr.delete();
    exp_data.delete();
    done_seen = 1'b0;
  endtask

  // Reset for two edges, optionally with a byte arriving on the first one
  // (caller must then be at a negedge); outputs are checked while reset holds.
  task automatic do_reset(input bit with_byte);
    if (with_byte) begin
      rx_valid = 1'b1;
      rx_data  = 8'h93;
    end else begin
      @(negedge clk);
    end
    reset = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    @(negedge clk);
    check_eq("rst_we",    imem_we,    1'b0);
    check_eq("rst_addr",  imem_addr,  '0);
    check_eq("rst_wdata", imem_wdata, 32'd0);
    check_eq("rst_hold",  cpu_hold,   1'b1);
    check_eq("rst_done",  load_done,  1'b0);
    check_eq("rst_err",   load_err,   1'b0);
    reset = 1'b0;
    clear_mon();
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic compare_writes(input string tag);
    int n;
    check_eq({tag, "_nwr"}, got_addr.size(), exp_addr.size());
    n = (got_addr.size() < exp_addr.size()) ? got_addr.size() : exp_addr.size();
    for (int i = 0; i < n; i++) begin
      check_eq($sformatf("%s_addr%0d", tag, i), got_addr[i], exp_addr[i]);
      check_eq($sformatf("%s_data%0d", tag, i), got_data[i], exp_data[i]);
    end
  endtask

  task automatic check_flags(input string tag, input bit done, input bit err);
    check_eq({tag, "_done"}, load_done, done);
    check_eq({tag, "_err"},  load_err,  err);
    check_eq({tag, "_hold"}, cpu_hold,  !done);
  endtask

  logic [7:0] boot2[10] = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
                            8'h93, 8'h00, 8'h10, 8'h00};

  task automatic run_boot2(input string tag);
    // Two words addressed 0 and 1.
    exp_addr.push_back(AW'(0)); exp_data.push_back(32'h0000_0013);
    exp_addr.push_back(AW'(1)); exp_data.push_back(32'h0010_0093);
    for (int i = 0; i < 10; i++) send_byte(boot2[i], 0);
    repeat (4) @(negedge clk);
    compare_writes(tag);
    check_flags(tag, 1'b1, 1'b0);
    check_eq({tag, "_done_lat"}, done_cyc, last_we_cyc + 1);
  endtask

  initial begin
    reset    = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;

    // Power-on reset values.
    do_reset(1'b0);

    // Two-word image, then hold of last write values and ignored extra bytes.
    run_boot2("boot2");
    check_eq("hold_addr",  imem_addr,  AW'(1));
    check_eq("hold_wdata", imem_wdata, 32'h0010_0093);
    for (int i = 0; i < 8; i++) send_byte(8'($urandom), $urandom_range(2, 0));
    repeat (3) @(negedge clk);
    check_eq("post_nwr", got_addr.size(), 2);
    check_flags("post", 1'b1, 1'b0);

    // Empty image.
    do_reset(1'b0);
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    repeat (3) @(negedge clk);
    compare_writes("empty");
    check_flags("empty", 1'b1, 1'b0);

    // Timeout with a partial word pending.
    do_reset(1'b0);
    send_byte(8'h01, 0);
    send_byte(8'h00, 0);
    send_byte(8'hAA, 0);
    send_byte(8'hBB, 0);
    repeat (TO - 1) @(negedge clk);
    check_flags("to_early", 1'b0, 1'b0);
    @(negedge clk);
    check_flags("to", 1'b0, 1'b1);
    repeat (5) @(negedge clk);
    compare_writes("to");

    // Oversized word count aborts at once; later bytes are ignored.
    do_reset(1'b0);
    send_byte(8'h11, 0);
    send_byte(8'h00, 0);
    check_flags("big", 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) send_byte(8'($urandom), 0);
    repeat (3) @(negedge clk);
    compare_writes("big");
    check_flags("big_end", 1'b0, 1'b1);

    // Reset mid-image with a coincident byte, then a clean reload.
    do_reset(1'b0);
    for (int i = 0; i < 6; i++) send_byte(boot2[i], 0);
    do_reset(1'b1);
    run_boot2("reload");

    // Randomized images checked against a word-list reference model.
    for (int it = 0; it < 30; it++) begin
      int n;
      int abort_at;
      bit stop;
      logic [31:0] word;
      string tag;
      tag = $sformatf("rnd%0d", it);
      n = $urandom_range(CAP + 2, 0);
      abort_at = -1;
      if (n >= 1 && n <= CAP && $urandom_range(3, 0) == 0)
        abort_at = $urandom_range(4 * n - 2, 0);
      do_reset(1'b0);
      send_byte(n[7:0], $urandom_range(3, 0));
      send_byte(n[15:8], $urandom_range(3, 0));
      stop = 1'b0;
      if (n > CAP) begin
        for (int b = 0; b < 6; b++) send_byte(8'($urandom), 0);
      end else begin
        for (int w = 0; w < n && !stop; w++) begin
          word = $urandom;
          for (int b = 0; b < 4 && !stop; b++) begin
            send_byte(word[8*b +: 8], $urandom_range(3, 0));
            if (b == 3) begin
              exp_addr.push_back(AW'(w));
              exp_data.push_back(word);
            end
            if (4 * w + b == abort_at) stop = 1'b1;
          end
        end
      end
      if (abort_at >= 0) repeat (TO + 5) @(negedge clk);
      else repeat (4) @(negedge clk);
      compare_writes(tag);
      check_flags(tag, (n <= CAP) && (abort_at < 0), (n > CAP) || (abort_at >= 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
